matrix_frame_scheduler: RTL and testbench
=========================================

// Module: matrix_frame_scheduler
// PURPOSE
//  Double-buffered frame controller for the 8x8 LED matrix.
//  A game/animation engine writes rows into a back buffer over a valid/ready port.
//  The block presents the front buffer by row-scanning segout/scanout.
//  Buffers swap only at a frame boundary (row 7 -> row 0), so a partly written frame is never shown.
// PARAMETERS
//  SCAN_DIV  8192  clk cycles each row is displayed (>=2); use 4 in simulation
// PORTS
//  clk         in   1  system clock
//  reset       in   1  asynchronous, active-low reset
//  wr_valid    in   1  row write request
//  wr_ready    out  1  back buffer accepts a write
//  wr_row      in   3  row index 0..7 of the write
//  wr_data     in   8  row pixels, 1 = LED lit (logical, active-high)
//  swap_req    in   1  1-cycle pulse: present back buffer at next frame boundary
//  swap_ack    out  1  1-cycle pulse: swap has taken effect
//  blank       in   1  level: force all LEDs off
//  frame_tick  out  1  1-cycle pulse at each frame boundary
//  segout      out  8  column drive, active-low (0 = lit)
//  scanout     out  3  row select currently driven
// BEHAVIOUR
//  Reset (async, reset==0): timer=0, scanout=0, segout=8'hFF, wr_ready=1.
//   swap_ack=0, frame_tick=0, swap_pending=0, front=bank0, both banks all 8'h00.
//   Mid-operation reset aborts any pending swap or write.
//  Row timer: counts 0..SCAN_DIV-1. When timer==SCAN_DIV-1:
//   timer<=0 and scanout<=scanout+1; scanout wraps 7->0.
//  Frame boundary (fb) = timer==SCAN_DIV-1 && scanout==7.
//   frame_tick is registered: high for 1 cycle, the cycle after fb. Period = 8*SCAN_DIV.
//  Write: accepted when wr_valid && wr_ready; back[wr_row]<=wr_data on that edge.
//   wr_ready = ~swap_pending, so the back buffer is frozen while a swap is pending.
//  Swap request:
//   swap_req sets swap_pending; swap_req while already pending is ignored (one swap only).
//   eff_swap = fb && (swap_pending || swap_req).
//   On eff_swap: front toggles, swap_pending<=0, swap_ack pulses the following cycle.
//   swap_req on the fb cycle swaps at that same boundary.
//   A write accepted on the eff_swap cycle lands in the old back bank, i.e. the new front.
//  After a swap the new back bank keeps the old front contents; it is not cleared.
//  segout is registered every cycle:
//   segout <= blank_in ? 8'hFF : ~front_next[scanout_next].
//   So segout and scanout change on the same edge.
//   New front content appears together with scanout 7->0 at the swap.
//   blank takes effect 1 cycle after it changes; the scan keeps running while blanked.
//  The front buffer is never written, so segout is stable within a row.
//  Widths: timer is $clog2(SCAN_DIV) bits, scanout 3-bit modulo-8, no saturation.
// TESTING (SCAN_DIV=4)
//  T1 Release reset -> segout=FF, scanout=0, wr_ready=1.
//     scanout=1 after 4 clks; frame_tick 1-cycle pulses every 32 clks.
//  T2 Write row3=A5, then pulse swap_req -> wr_ready=0 until fb, swap_ack pulses.
//     Then segout=5A while scanout=3; segout=FF on other rows.
//  T3 wr_valid with row2=FF while swap pending -> not accepted.
//     After swap, row2 still shows FF (unlit).
//  T4 blank=1 mid-row -> segout=FF next clk and scanout keeps counting.
//     blank=0 -> row data returns next clk.
//  T5 swap_req plus write row0=81 on the fb cycle -> swap at that boundary.
//     segout=7E on scanout=0 immediately after.
//  T6 Assert reset mid-frame with a swap pending -> all reset values.
//     No swap_ack; display all off after reset release.

Source files
------------

// File: rtl/matrix_frame_scheduler.sv
// Double-buffered 8x8 LED matrix frame controller.
// Rows are written into a back bank and the front bank is row-scanned out.
module matrix_frame_scheduler #(
    parameter int SCAN_DIV = 8192
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [2:0] wr_row,
    input  logic [7:0] wr_data,
    input  logic       swap_req,
    output logic       swap_ack,
    input  logic       blank,
    output logic       frame_tick,
    output logic [7:0] segout,
    output logic [2:0] scanout
);

    localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [TW-1:0] timer;
    logic          row_end;
    logic          fb;
    logic          eff_swap;
    logic          wr_fire;
    logic          front;
    logic          front_next;
    logic          swap_pending;
    logic [2:0]    scan_next;
    logic [7:0]    row_next;
    logic [7:0]    bank [2][8];

    assign wr_ready = ~swap_pending;

    always_comb begin
        row_end    = (timer == TW'(SCAN_DIV - 1));
        fb         = row_end && (scanout == 3'd7);
        eff_swap   = fb && (swap_pending || swap_req);
        wr_fire    = wr_valid && wr_ready;
        front_next = front ^ eff_swap;
        scan_next  = row_end ? scanout + 3'd1 : scanout;
        row_next   = bank[front_next][scan_next];
        // A write landing on the swap edge targets the bank that becomes front.
        if (wr_fire && eff_swap && (wr_row == scan_next))
            row_next = wr_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer        <= '0;
            scanout      <= 3'd0;
            segout       <= 8'hFF;
            swap_ack     <= 1'b0;
            frame_tick   <= 1'b0;
            swap_pending <= 1'b0;
            front        <= 1'b0;
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < 8; r++)
                    bank[b][r] <= 8'h00;
        end else begin
            timer      <= row_end ? '0 : timer + 1'b1;
            scanout    <= scan_next;
            frame_tick <= fb;
            swap_ack   <= eff_swap;
            front      <= front_next;
            if (eff_swap)
                swap_pending <= 1'b0;
            else if (swap_req)
                swap_pending <= 1'b1;
            if (wr_fire)
                bank[~front][wr_row] <= wr_data;
            segout <= blank ? 8'hFF : ~row_next;
        end
    end

endmodule

// File: tb/tb_matrix_frame_scheduler.sv
// Scoreboard bench for matrix_frame_scheduler with SCAN_DIV=4.
// Expected frames are queued when writes/swaps are driven, checked as rows scan.
module tb_matrix_frame_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_valid;
    logic       wr_ready;
    logic [2:0] wr_row;
    logic [7:0] wr_data;
    logic       swap_req;
    logic       swap_ack;
    logic       blank;
    logic       frame_tick;
    logic [7:0] segout;
    logic [2:0] scanout;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] sh_front [8];
    logic [7:0] sh_back  [8];
    logic [7:0] seg_q [$];
    int         tick_q [$];

    matrix_frame_scheduler #(.SCAN_DIV(4)) dut (
        .clk(clk),
        .reset(reset),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_row(wr_row),
        .wr_data(wr_data),
        .swap_req(swap_req),
        .swap_ack(swap_ack),
        .blank(blank),
        .frame_tick(frame_tick),
        .segout(segout),
        .scanout(scanout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int t);
        while (cyc < t) step();
    endtask

    task automatic model_swap();
        logic [7:0] t;
        for (int r = 0; r < 8; r++) begin
            t = sh_front[r];
            sh_front[r] = sh_back[r];
            sh_back[r] = t;
        end
    endtask

    task automatic push_frame();
        for (int r = 0; r < 8; r++) seg_q.push_back(~sh_front[r]);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        wr_valid = 1'b0;
        wr_row = 3'd0;
        wr_data = 8'h00;
        swap_req = 1'b0;
        blank = 1'b0;
        for (int r = 0; r < 8; r++) begin
            sh_front[r] = 8'h00;
            sh_back[r] = 8'h00;
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (segout !== 8'hFF || scanout !== 3'd0 || wr_ready !== 1'b1
            || swap_ack !== 1'b0 || frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset: seg=%h scan=%0d rdy=%b ack=%b tick=%b",
                     segout, scanout, wr_ready, swap_ack, frame_tick);
        end
        reset = 1'b1;
        cyc = 0;
    endtask

    task automatic test_scan();
        int t;
        run_to(4);
        checks++;
        if (scanout !== 3'd1) begin
            errors++;
            $display("FAIL scan_row1: scanout=%0d want 1", scanout);
        end
        tick_q.push_back(32);
        tick_q.push_back(64);
        while (cyc < 65) begin
            step();
            if (frame_tick === 1'b1) begin
                checks++;
                if (tick_q.size() == 0) begin
                    errors++;
                    $display("FAIL frame_tick_extra: at cyc %0d", cyc);
                end else begin
                    t = tick_q.pop_front();
                    if (cyc != t) begin
                        errors++;
                        $display("FAIL frame_tick_time: got %0d want %0d",
                                 cyc, t);
                    end
                end
            end
            if (segout !== 8'hFF) begin
                checks++;
                errors++;
                $display("FAIL blank_frame: seg=%h want ff", segout);
            end
        end
        checks++;
        if (tick_q.size() != 0) begin
            errors++;
            $display("FAIL frame_tick_missing: %0d left want 0",
                     tick_q.size());
        end
    endtask

    task automatic test_swap();
        int n = 0;
        logic [7:0] e;
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL wr_ready_idle: got %b want 1", wr_ready);
        end
        wr_valid = 1'b1;
        wr_row = 3'd3;
        wr_data = 8'hA5;
        sh_back[3] = 8'hA5;
        step();
        wr_valid = 1'b0;
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        checks++;
        if (wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL wr_ready_pending: got %b want 0", wr_ready);
        end
        wr_valid = 1'b1;
        wr_row = 3'd2;
        wr_data = 8'hFF;
        run_to(80);
        checks++;
        if (wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL wr_frozen: got %b want 0", wr_ready);
        end
        wr_valid = 1'b0;
        model_swap();
        push_frame();
        while (swap_ack !== 1'b1 && n < 64) begin
            step();
            n++;
        end
        checks++;
        if (swap_ack !== 1'b1 || cyc != 96 || wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL swap_ack: ack=%b cyc=%0d rdy=%b want 1 96 1",
                     swap_ack, cyc, wr_ready);
        end
        for (int r = 0; r < 8; r++) begin
            run_to(96 + 4 * r + 1);
            e = seg_q.pop_front();
            checks++;
            if (segout !== e || scanout !== 3'(r)) begin
                errors++;
                $display("FAIL swap_frame row%0d: seg=%h scan=%0d want %h",
                         r, segout, scanout, e);
            end
        end
    endtask

    task automatic test_blank();
        logic [7:0] e;
        run_to(138);
        blank = 1'b1;
        seg_q.push_back(8'hFF);
        seg_q.push_back(8'hFF);
        seg_q.push_back(~sh_front[3]);
        step();
        e = seg_q.pop_front();
        checks++;
        if (segout !== e || scanout !== 3'd2) begin
            errors++;
            $display("FAIL blank_on: seg=%h scan=%0d want %h 2",
                     segout, scanout, e);
        end
        step();
        e = seg_q.pop_front();
        checks++;
        if (segout !== e || scanout !== 3'd3) begin
            errors++;
            $display("FAIL blank_scan: seg=%h scan=%0d want %h 3",
                     segout, scanout, e);
        end
        step();
        blank = 1'b0;
        step();
        e = seg_q.pop_front();
        checks++;
        if (segout !== e || scanout !== 3'd3) begin
            errors++;
            $display("FAIL blank_off: seg=%h scan=%0d want %h 3",
                     segout, scanout, e);
        end
    endtask

    task automatic test_fb_swap();
        logic [7:0] e;
        run_to(159);
        checks++;
        if (wr_ready !== 1'b1 || scanout !== 3'd7) begin
            errors++;
            $display("FAIL fb_pre: rdy=%b scan=%0d want 1 7",
                     wr_ready, scanout);
        end
        swap_req = 1'b1;
        wr_valid = 1'b1;
        wr_row = 3'd0;
        wr_data = 8'h81;
        sh_back[0] = 8'h81;
        model_swap();
        push_frame();
        step();
        swap_req = 1'b0;
        wr_valid = 1'b0;
        checks++;
        if (swap_ack !== 1'b1 || frame_tick !== 1'b1 || scanout !== 3'd0
            || segout !== 8'h7E) begin
            errors++;
            $display("FAIL fb_swap: ack=%b tick=%b scan=%0d seg=%h want 1 1 0 7e",
                     swap_ack, frame_tick, scanout, segout);
        end
        for (int r = 0; r < 8; r++) begin
            run_to(160 + 4 * r + 1);
            e = seg_q.pop_front();
            checks++;
            if (segout !== e || scanout !== 3'(r)) begin
                errors++;
                $display("FAIL fb_frame row%0d: seg=%h scan=%0d want %h",
                         r, segout, scanout, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        logic [7:0] e;
        run_to(195);
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        run_to(200);
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        model_swap();
        push_frame();
        while (swap_ack !== 1'b1 && n < 64) begin
            step();
            n++;
        end
        checks++;
        if (swap_ack !== 1'b1 || cyc != 224) begin
            errors++;
            $display("FAIL b2b_ack: ack=%b cyc=%0d want 1 224", swap_ack, cyc);
        end
        for (int r = 0; r < 8; r++) begin
            run_to(224 + 4 * r + 1);
            e = seg_q.pop_front();
            checks++;
            if (segout !== e) begin
                errors++;
                $display("FAIL b2b_frame row%0d: seg=%h want %h", r, segout, e);
            end
        end
        while (cyc < 260) begin
            step();
            checks++;
            if (swap_ack !== 1'b0) begin
                errors++;
                $display("FAIL b2b_second_ack: ack=%b at %0d want 0",
                         swap_ack, cyc);
            end
        end
    endtask

    task automatic test_reset_mid();
        wr_valid = 1'b1;
        wr_row = 3'd5;
        wr_data = 8'h3C;
        swap_req = 1'b1;
        step();
        wr_valid = 1'b0;
        swap_req = 1'b0;
        run_to(266);
        checks++;
        if (wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_pre_pending: rdy=%b want 0", wr_ready);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (segout !== 8'hFF || scanout !== 3'd0 || wr_ready !== 1'b1
            || swap_ack !== 1'b0 || frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: seg=%h scan=%0d rdy=%b ack=%b tick=%b",
                     segout, scanout, wr_ready, swap_ack, frame_tick);
        end
        step();
        step();
        reset = 1'b1;
        cyc = 0;
        while (cyc < 40) begin
            step();
            checks++;
            if (swap_ack !== 1'b0 || segout !== 8'hFF) begin
                errors++;
                $display("FAIL rst_after: ack=%b seg=%h at %0d want 0 ff",
                         swap_ack, segout, cyc);
            end
        end
        checks++;
        if (scanout !== 3'd2) begin
            errors++;
            $display("FAIL rst_scan: scanout=%0d want 2", scanout);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_swap();
        test_blank();
        test_fb_swap();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
